buffer_pixeles_fifo: RTL

BUFFER_PIXELES_FIFO -- requirements
Module: buffer_pixeles_fifo

---
 rtl/buffer_pixeles_fifo_pkg.sv | 8 +
 rtl/buffer_pixeles_fifo_if.sv | 27 ++
 rtl/buffer_pixeles_fifo_selector_pixel_palabra.sv | 20 ++
 rtl/buffer_pixeles_fifo.sv | 57 +++++
 4 files changed

// File: rtl/buffer_pixeles_fifo_pkg.sv
// buffer_pixeles_fifo_pkg: shared width defaults and the clog2 helper for the pixel FIFO
package buffer_pixeles_fifo_pkg;
  localparam int DEF_MEM_WORD_BITS = 32;
  localparam int DEF_PIXEL_BITS = 8;
  function automatic int clog2(input int v);
    return $clog2(v);
  endfunction
endpackage

// File: rtl/buffer_pixeles_fifo_if.sv
// buffer_pixeles_fifo_if: memory-side write port, pixel-side read port and status of the pixel FIFO
interface buffer_pixeles_fifo_if
  import buffer_pixeles_fifo_pkg::*;
#(
  parameter int MEM_WORD_BITS = DEF_MEM_WORD_BITS,
  parameter int PIXEL_BITS = DEF_PIXEL_BITS,
  parameter int DEPTH_WORDS = 4
);
  localparam int CW = clog2(DEPTH_WORDS) + 1;
  logic [MEM_WORD_BITS-1:0] memory_data;
  logic save_mem_data;
  logic read_pixel;
  logic flush;
  logic msb_first;
  logic [PIXEL_BITS-1:0] pixel;
  logic space_available;
  logic data_available;
  logic [CW-1:0] word_count;
  modport master (
    output memory_data, save_mem_data, read_pixel, flush, msb_first,
    input pixel, space_available, data_available, word_count
  );
  modport slave (
    input memory_data, save_mem_data, read_pixel, flush, msb_first,
    output pixel, space_available, data_available, word_count
  );
endinterface

// File: rtl/buffer_pixeles_fifo_selector_pixel_palabra.sv
// selector_pixel_palabra: picks one pixel out of a memory word by index and ordering
module selector_pixel_palabra
  import buffer_pixeles_fifo_pkg::*;
#(
  parameter int MEM_WORD_BITS = DEF_MEM_WORD_BITS,
  parameter int PIXEL_BITS = DEF_PIXEL_BITS,
  parameter int PPW = MEM_WORD_BITS / PIXEL_BITS,
  parameter int IW = clog2(PPW)
) (
  input  logic [MEM_WORD_BITS-1:0] word,
  input  logic [IW-1:0]            index,
  input  logic                     msb_first,
  output logic [PIXEL_BITS-1:0]    pixel
);
  logic [PPW-1:0][PIXEL_BITS-1:0] pix;
  logic [IW-1:0] sel;
  assign pix = word;
  assign sel = msb_first ? IW'(PPW - 1) - index : index;
  assign pixel = pix[sel];
endmodule

// File: rtl/buffer_pixeles_fifo.sv
// buffer_pixeles_fifo: word-wide circular FIFO drained one pixel at a time
module buffer_pixeles_fifo
  import buffer_pixeles_fifo_pkg::*;
#(
  parameter int MEM_WORD_BITS = DEF_MEM_WORD_BITS,
  parameter int PIXEL_BITS = DEF_PIXEL_BITS,
  parameter int DEPTH_WORDS = 4
) (
  input logic clk,
  input logic reset,
  buffer_pixeles_fifo_if.slave bus
);
  localparam int PPW = MEM_WORD_BITS / PIXEL_BITS;
  localparam int IW = clog2(PPW);
  localparam int AW = clog2(DEPTH_WORDS);
  localparam int CW = AW + 1;
  logic [MEM_WORD_BITS-1:0] mem [DEPTH_WORDS];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [IW-1:0] idx;
  logic [CW-1:0] count;
  logic wr_ok, rd_ok, free;
  assign bus.space_available = count < CW'(DEPTH_WORDS);
  assign bus.data_available = count != '0;
  assign bus.word_count = count;
  assign wr_ok = bus.save_mem_data & bus.space_available;
  assign rd_ok = bus.read_pixel & bus.data_available;
  assign free = rd_ok & (idx == IW'(PPW - 1));
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      idx <= '0;
      count <= '0;
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      idx <= '0;
      count <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) idx <= free ? '0 : idx + 1'b1;
      if (free) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(wr_ok) - CW'(free);
    end
  // slot contents are deliberately left out of reset
  always_ff @(posedge clk)
    if (wr_ok && !bus.flush) mem[wr_ptr] <= bus.memory_data;
  selector_pixel_palabra #(
    .MEM_WORD_BITS(MEM_WORD_BITS),
    .PIXEL_BITS(PIXEL_BITS)
  ) u_sel (
    .word(mem[rd_ptr]),
    .index(idx),
    .msb_first(bus.msb_first),
    .pixel(bus.pixel)
  );
endmodule
